// File: rtl/load_store_memory.sv
// Word-organised data memory with byte/half/word loads and stores.
// Loads return after READ_LATENCY edges; illegal requests pulse Error for one cycle.
module load_store_memory #(
   parameter int ADDR_WIDTH   = 8,
   parameter int READ_LATENCY = 1
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [31:0] Address,
   input  logic [31:0] Write_Data,
   input  logic        Mem_Write,
   input  logic        Mem_Read,
   input  logic [2:0]  Funct3,
   output logic [31:0] Read_Data,
   output logic        Read_Valid,
   output logic        Busy,
   output logic        Error
);

   localparam int LP_LAT   = (READ_LATENCY >= 1 && READ_LATENCY <= 4) ? READ_LATENCY : 1;
   localparam int LP_DEPTH = 1 << ADDR_WIDTH;
   localparam logic [LP_LAT-1:0] LP_TOP = LP_LAT'(1) << (LP_LAT - 1);

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   logic [31:0]           r_mem [LP_DEPTH];
   logic [LP_LAT-1:0]     r_vld_pipe;
   logic [31:0]           r_ld_data;
   logic [31:0]           r_rdata;
   logic                  r_error;

   logic [LP_LAT-1:0]     w_vld_next;
   logic                  w_busy;
   logic                  w_open;
   logic                  w_f3_bad;
   logic                  w_misalign;
   logic                  w_oor;
   logic                  w_illegal;
   logic                  w_st_acc;
   logic                  w_ld_acc;
   logic                  w_err_next;
   logic [ADDR_WIDTH-1:0] w_idx;
   logic [1:0]            w_lane;
   logic [3:0]            w_be;
   logic [31:0]           w_wdata;
   logic [31:0]           w_word;
   logic [31:0]           w_shifted;
   logic [31:0]           w_ext;

   // Request decode and acceptance
   always_comb begin
      w_idx      = Address[ADDR_WIDTH+1:2];
      w_lane     = Address[1:0];
      // At most one load is in flight, so the pipe is one-hot; the top bit is the
      // Read_Valid cycle, every earlier stage counts as busy.
      w_busy     = |(r_vld_pipe & ~LP_TOP);
      w_open     = !Reset && !w_busy;
      w_f3_bad   = (Funct3 == 3'b011) || (Funct3 == 3'b110) || (Funct3 == 3'b111);
      w_misalign = (((Funct3 == F3_H) || (Funct3 == F3_HU)) && Address[0]) ||
                   ((Funct3 == F3_W) && (Address[1:0] != 2'b00));
      w_oor      = (Address >> (ADDR_WIDTH + 2)) != 32'd0;
      w_illegal  = w_f3_bad || w_misalign || w_oor;
      w_st_acc   = w_open && Mem_Write && !Mem_Read && !w_illegal;
      w_ld_acc   = w_open && Mem_Read && !Mem_Write && !w_illegal;
      w_err_next = w_open && ((Mem_Read && Mem_Write) || ((Mem_Read ^ Mem_Write) && w_illegal));
      w_vld_next = (r_vld_pipe << 1) | LP_LAT'(w_ld_acc);
   end

   // Store lane enables and lane-aligned data
   always_comb begin
      case (Funct3[1:0])
         2'b00:   w_be = 4'b0001 << w_lane;
         2'b01:   w_be = 4'b0011 << w_lane;
         default: w_be = 4'b1111;
      endcase
      w_wdata = Write_Data << {w_lane, 3'b000};
   end

   // Load extraction and extension
   always_comb begin
      w_word    = r_mem[w_idx];
      w_shifted = w_word >> {w_lane, 3'b000};
      case (Funct3)
         F3_B:    w_ext = {{24{w_shifted[7]}},  w_shifted[7:0]};
         F3_H:    w_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
         F3_BU:   w_ext = {24'd0, w_shifted[7:0]};
         F3_HU:   w_ext = {16'd0, w_shifted[15:0]};
         default: w_ext = w_word;
      endcase
   end

   // Contents survive reset; stores are blocked by the acceptance term instead
   always_ff @(posedge Clk) begin
      if (w_st_acc) begin
         for (int i = 0; i < 4; i++) begin
            if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_vld_pipe <= '0;
         r_ld_data  <= '0;
         r_rdata    <= '0;
         r_error    <= 1'b0;
      end else begin
         r_vld_pipe <= w_vld_next;
         r_error    <= w_err_next;
         if (w_ld_acc) r_ld_data <= w_ext;
         // Data is captured at acceptance, so later stalls cannot see a stale word
         if (w_vld_next[LP_LAT-1]) r_rdata <= (LP_LAT == 1) ? w_ext : r_ld_data;
      end
   end

   assign Read_Data  = r_rdata;
   assign Read_Valid = r_vld_pipe[LP_LAT-1];
   assign Busy       = w_busy;
   assign Error      = r_error;

endmodule

// File: tb/tb_load_store_memory.sv
// Scoreboard bench: one instance at READ_LATENCY=1 and one at 3, checked against
// a byte-array reference model with a cycle-stamped expectation queue.
module tb_load_store_memory;

   localparam int AW = 8;
   localparam int NW = 1 << AW;
   localparam int NB = NW * 4;

   localparam logic [2:0] F_B  = 3'b000;
   localparam logic [2:0] F_H  = 3'b001;
   localparam logic [2:0] F_W  = 3'b010;
   localparam logic [2:0] F_BU = 3'b100;
   localparam logic [2:0] F_HU = 3'b101;

   logic Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic [1:0]  rst, rd, wr, rv, busy, err;
   logic [2:0]  f3    [2];
   logic [31:0] addr  [2];
   logic [31:0] wd    [2];
   logic [31:0] rdata [2];

   load_store_memory #(.ADDR_WIDTH(AW), .READ_LATENCY(1)) u_dut_l1 (
      .Clk(Clk), .Reset(rst[0]), .Address(addr[0]), .Write_Data(wd[0]),
      .Mem_Write(wr[0]), .Mem_Read(rd[0]), .Funct3(f3[0]),
      .Read_Data(rdata[0]), .Read_Valid(rv[0]), .Busy(busy[0]), .Error(err[0]));

   load_store_memory #(.ADDR_WIDTH(AW), .READ_LATENCY(3)) u_dut_l3 (
      .Clk(Clk), .Reset(rst[1]), .Address(addr[1]), .Write_Data(wd[1]),
      .Mem_Write(wr[1]), .Mem_Read(rd[1]), .Funct3(f3[1]),
      .Read_Data(rdata[1]), .Read_Valid(rv[1]), .Busy(busy[1]), .Error(err[1]));

   typedef struct {
      int          dut;
      int          due;
      bit          is_err;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   int          cyc = 0;
   int          lat      [2] = '{1, 3};
   int          ready_e  [2];
   int          bfrom    [2];
   int          bto      [2];
   int          rst_edge [2];
   logic [31:0] last_exp [2];
   logic [7:0]  mb [2][NB];
   int          checks = 0;
   int          failures = 0;
   bit          mon_on = 1'b0;

   always @(posedge Clk) cyc <= cyc + 1;

   function automatic void chk(bit ok, string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
      end
   endfunction

   // ---------------- reference model ----------------
   function automatic int size_of(logic [2:0] f);
      if (f[1:0] == 2'b10) return 4;
      if (f[1:0] == 2'b01) return 2;
      return 1;
   endfunction

   function automatic bit legal(logic [2:0] f, logic [31:0] a);
      if (f == 3'b011 || f == 3'b110 || f == 3'b111) return 1'b0;
      if ((f == F_H || f == F_HU) && (a % 2) != 0) return 1'b0;
      if (f == F_W && (a % 4) != 0) return 1'b0;
      if (a >= 32'(NB)) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [31:0] model_load(int d, logic [2:0] f, logic [31:0] a);
      logic [31:0] v;
      v = 32'd0;
      for (int i = 0; i < size_of(f); i++) v = v | (32'(mb[d][int'(a) + i]) << (8 * i));
      if (f == F_B && v[7])  v = v | 32'hFFFF_FF00;
      if (f == F_H && v[15]) v = v | 32'hFFFF_0000;
      return v;
   endfunction

   function automatic void model_store(int d, logic [2:0] f, logic [31:0] a, logic [31:0] dat);
      for (int i = 0; i < size_of(f); i++) mb[d][int'(a) + i] = 8'(dat >> (8 * i));
   endfunction

   // ---------------- stimulus ----------------
   task automatic req(int d, bit r, bit w, logic [2:0] f, logic [31:0] a, logic [31:0] dat);
      int   e;
      exp_t x;
      e = cyc + 1;
      rd[d] = r; wr[d] = w; f3[d] = f; addr[d] = a; wd[d] = dat;
      if ((r || w) && e >= ready_e[d]) begin
         x.dut = d; x.is_err = 1'b0; x.data = 32'd0; x.due = e;
         if ((r && w) || !legal(f, a)) begin
            x.is_err = 1'b1;
            sb.push_back(x);
         end else if (w) begin
            model_store(d, f, a, dat);
         end else begin
            x.due  = e + lat[d] - 1;
            x.data = model_load(d, f, a);
            sb.push_back(x);
            ready_e[d] = e + lat[d];
            bfrom[d]   = e;
            bto[d]     = e + lat[d] - 2;
         end
      end
      @(negedge Clk);
      rd[d] = 1'b0; wr[d] = 1'b0;
   endtask

   task automatic do_reset(int d, bit with_st);
      int e;
      e = cyc + 1;
      rst[d] = 1'b1;
      if (with_st) begin
         wr[d] = 1'b1; f3[d] = F_W; addr[d] = 32'h0C; wd[d] = 32'hBAD0_BAD0;
      end
      rst_edge[d] = e;
      for (int i = sb.size() - 1; i >= 0; i--)
         if (sb[i].dut == d && sb[i].due >= e) sb.delete(i);
      if (bto[d] > cyc) bto[d] = cyc;
      ready_e[d] = e + 1;
      @(negedge Clk);
      rst[d] = 1'b0; wr[d] = 1'b0; rd[d] = 1'b0;
   endtask

   task automatic rand_ops(int d, int n);
      int          k;
      bit          r, w;
      logic [2:0]  f;
      logic [31:0] a;
      for (int i = 0; i < n; i++) begin
         if (d == 1 && (i % 300) == 150) do_reset(d, 1'b1);
         k = $urandom_range(0, 99);
         w = (k < 45) || (k >= 90 && k < 95);
         r = (k >= 45 && k < 95);
         if (w && !r) f = 3'($urandom_range(0, 2));
         else         f = 3'($urandom_range(0, 5));
         if ($urandom_range(0, 19) == 0) f = 3'b110;
         a = 32'($urandom_range(0, NB - 1));
         if ($urandom_range(0, 9) < 8) a = a & ~32'(size_of(f) - 1);
         if ($urandom_range(0, 24) == 0) a = a | (32'h400 << $urandom_range(0, 21));
         req(d, r, w, f, a, $urandom);
      end
   endtask

   // ---------------- monitor ----------------
   function automatic void mon(int d);
      int idx;
      bit exp_busy;
      idx = -1;
      if (cyc == rst_edge[d]) last_exp[d] = 32'd0;
      for (int i = 0; i < sb.size(); i++) begin
         if (sb[i].dut == d) begin
            idx = i;
            break;
         end
      end
      if (idx >= 0 && sb[idx].due == cyc) begin
         if (sb[idx].is_err) begin
            chk(err[d] === 1'b1 && rv[d] === 1'b0, "error_pulse", {30'd0, rv[d], err[d]}, 32'h1);
         end else begin
            chk(rv[d] === 1'b1 && err[d] === 1'b0, "read_valid", {30'd0, rv[d], err[d]}, 32'h2);
            chk(rdata[d] === sb[idx].data, "read_data", rdata[d], sb[idx].data);
            last_exp[d] = sb[idx].data;
         end
         sb.delete(idx);
      end else begin
         chk(rv[d] === 1'b0 && err[d] === 1'b0, "no_pulse", {30'd0, rv[d], err[d]}, 32'h0);
         chk(rdata[d] === last_exp[d], "read_data_hold", rdata[d], last_exp[d]);
      end
      exp_busy = (cyc >= bfrom[d]) && (cyc <= bto[d]);
      chk(busy[d] === exp_busy, "busy", {31'd0, busy[d]}, {31'd0, exp_busy});
   endfunction

   always @(negedge Clk) begin
      if (mon_on) begin
         for (int d = 0; d < 2; d++) mon(d);
      end
   end

   // ---------------- sequence ----------------
   initial begin
      rst = 2'b11; rd = 2'b00; wr = 2'b00;
      for (int d = 0; d < 2; d++) begin
         f3[d] = 3'd0; addr[d] = 32'd0; wd[d] = 32'd0;
         bfrom[d] = 0; bto[d] = -1; rst_edge[d] = -1; last_exp[d] = 32'd0;
      end
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      for (int d = 0; d < 2; d++) begin
         chk(rdata[d] === 32'd0, "reset_read_data", rdata[d], 32'd0);
         chk(rv[d] === 1'b0 && busy[d] === 1'b0 && err[d] === 1'b0, "reset_flags",
             {29'd0, rv[d], busy[d], err[d]}, 32'd0);
         ready_e[d] = cyc + 1;
      end
      rst = 2'b00;
      mon_on = 1'b1;

      // Preload so every model byte is defined
      fork
         for (int w0 = 0; w0 < NW; w0++) req(0, 1'b0, 1'b1, F_W, 32'(w0 * 4), $urandom);
         for (int w1 = 0; w1 < NW; w1++) req(1, 1'b0, 1'b1, F_W, 32'(w1 * 4), $urandom);
      join

      // Store then load with each extension
      req(0, 0, 1, F_W,  32'h0C, 32'h8000_00FF);
      req(0, 1, 0, F_W,  32'h0C, 32'h0);
      req(0, 1, 0, F_B,  32'h0C, 32'h0);
      req(0, 1, 0, F_BU, 32'h0C, 32'h0);

      // Lane masking
      req(0, 0, 1, F_W,  32'h10, 32'h1122_3344);
      req(0, 0, 1, F_B,  32'h11, 32'h0000_00AA);
      req(0, 0, 1, F_H,  32'h12, 32'h0000_BEEF);
      req(0, 1, 0, F_W,  32'h10, 32'h0);
      req(0, 1, 0, F_H,  32'h12, 32'h0);
      req(0, 1, 0, F_HU, 32'h12, 32'h0);

      // Rejected requests leave memory alone
      req(0, 1, 0, F_W,    32'h0E,  32'h0);
      req(0, 0, 1, F_H,    32'h11,  32'h5555_5555);
      req(0, 0, 1, 3'b011, 32'h10,  32'h6666_6666);
      req(0, 1, 0, F_W,    32'h400, 32'h0);
      req(0, 0, 1, F_W,    32'h400, 32'h7777_7777);
      req(0, 1, 1, F_W,    32'h10,  32'h8888_8888);
      req(0, 1, 0, F_W,    32'h10,  32'h0);
      req(0, 1, 0, F_W,    32'h0C,  32'h0);

      // Latency 3: busy window, ignored requests
      req(1, 0, 1, F_W, 32'h0C, 32'h1234_5678);
      req(1, 1, 0, F_W, 32'h0C, 32'h0);
      req(1, 1, 0, F_W, 32'h10, 32'h0);
      req(1, 0, 1, F_W, 32'h0C, 32'hDEAD_BEEF);
      req(1, 1, 0, F_W, 32'h0C, 32'h0);
      repeat (3) @(negedge Clk);

      // Reset aborts an in-flight load and blocks a store on the reset edge
      req(1, 1, 0, F_W, 32'h0C, 32'h0);
      do_reset(1, 1'b1);
      repeat (2) @(negedge Clk);
      req(1, 1, 0, F_W, 32'h0C, 32'h0);
      repeat (3) @(negedge Clk);

      // Back-to-back store/load over 16 words
      for (int i = 0; i < 16; i++) begin
         req(0, 0, 1, F_W, 32'(32'h40 + i * 4), $urandom);
         req(0, 1, 0, 3'($urandom_range(0, 2)), 32'(32'h40 + i * 4), 32'h0);
      end

      fork
         rand_ops(0, 1500);
         rand_ops(1, 1500);
      join

      repeat (6) @(negedge Clk);
      chk(sb.size() == 0, "scoreboard_drain", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/load_store_memory.md
LOAD_STORE_MEMORY -- requirements
Module: load_store_memory

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, the word-address bit count (memory holds 2^ADDR_WIDTH 32-bit words).
REQ-002 The block SHALL have parameter READ_LATENCY, default 1, legal 1..4, the number of clock edges from read acceptance to Read_Valid.
REQ-003 The block SHALL have port Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 The block SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port Address  input  32  byte address of the access.
REQ-006 The block SHALL have port Write_Data  input  32  store data, right-justified for byte/half stores.
REQ-007 The block SHALL have port Mem_Write  input  1  store request.
REQ-008 The block SHALL have port Mem_Read  input  1  load request.
REQ-009 The block SHALL have port Funct3  input  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 The block SHALL have port Read_Data  output  32  load result, sign/zero-extended.
REQ-011 The block SHALL have port Read_Valid  output  1  one-cycle pulse qualifying Read_Data.
REQ-012 The block SHALL have port Busy  output  1  load in flight; new requests ignored.
REQ-013 The block SHALL have port Error  output  1  one-cycle pulse flagging a rejected request.

Function
REQ-014 A request SHALL be accepted on a rising edge when exactly one of Mem_Read or Mem_Write is high, Busy is low and Reset is low.
REQ-015 Requests presented while Busy is high SHALL be ignored, with no Error and no memory change.
REQ-016 Mem_Read and Mem_Write both high while not Busy SHALL be rejected, with Error pulsing on the next cycle and no access.
REQ-017 A request SHALL be rejected, with an Error pulse and no access, on any of:
- Funct3 in {011, 110, 111};
- H/HU with Address[0]=1;
- W with Address[1:0]!=00;
- Address[31:ADDR_WIDTH+2] nonzero.
REQ-018 Lane mapping SHALL be little-endian: byte lane n = bits [8n+7:8n] of word Address[ADDR_WIDTH+1:2], with n = Address[1:0].
REQ-019 A store SHALL commit on its acceptance edge, writing only the addressed lanes:
- B: one lane from Write_Data[7:0];
- H: lanes n, n+1 from Write_Data[15:0];
- W: all four lanes.
REQ-020 Load extension SHALL be: B/H sign-extend, BU/HU zero-extend, W unmodified.
REQ-021 A load accepted at edge k SHALL present Read_Data with Read_Valid=1 for exactly the cycle following edge k+READ_LATENCY-1.
REQ-022 Busy SHALL be high from edge k until the edge that raises Read_Valid; with READ_LATENCY=1 Busy SHALL never assert.
REQ-023 Read_Data SHALL hold its last value when Read_Valid is low.
REQ-024 A load accepted on the edge after a store to the same word SHALL return the stored data, with no stale read.
REQ-025 Stores SHALL never assert Busy or Read_Valid, permitting back-to-back stores every cycle.
REQ-026 When READ_LATENCY=1, back-to-back loads every cycle SHALL be supported.
REQ-027 Out-of-range READ_LATENCY SHALL be treated as 1.

Reset
REQ-028 While Reset is high at an edge, the block SHALL drive Read_Data=0, Read_Valid=0, Busy=0 and Error=0.
REQ-029 Reset SHALL abort any in-flight load, so that no Read_Valid follows.
REQ-030 Reset SHALL block any store presented on a reset edge, leaving memory unchanged.
REQ-031 Memory contents SHALL be preserved across Reset and not cleared.

Verification
REQ-032 Store and load at READ_LATENCY=1: SW 0x8000_00FF to addr 0x0C, then LW 0x0C -> Read_Valid one cycle after acceptance, Read_Data=0x8000_00FF; LB 0x0C -> 0xFFFF_FFFF; LBU 0x0C -> 0x0000_00FF.
REQ-033 Lane masking: SW 0x1122_3344 to 0x10; SB 0xAA to 0x11; SH 0xBEEF to 0x12; LW 0x10 -> 0xBEEF_AA44; LH 0x12 -> 0xFFFF_BEEF; LHU 0x12 -> 0x0000_BEEF.
REQ-034 Errors: LW 0x0E, SH 0x11, Funct3=011, address 0x0000_0400 (ADDR_WIDTH=8), both enables high -> each gives a one-cycle Error, no Read_Valid, and a subsequent LW shows memory unchanged.
REQ-035 Latency: READ_LATENCY=3, LW 0x0C accepted at edge k -> Busy high for the two cycles after edges k and k+1, a second LW at edge k+1 is ignored, and Read_Valid goes high after edge k+2 with correct data.
REQ-036 Reset mid-load: READ_LATENCY=3, LW accepted, Reset high at the next edge -> no Read_Valid, Busy=0, and a later LW returns pre-reset memory contents.
REQ-037 Back-to-back traffic: alternate SW and LW on consecutive cycles over 16 addresses, against a bench reference model -> every Read_Data matches the model.
